// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
package arb_pkg;

  localparam int N_REQ_DEFAULT = 2;

  typedef logic [N_REQ_DEFAULT-1:0] req_vec_t;

  function automatic req_vec_t onehot(input int unsigned idx);
    req_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_if.sv
// Request/grant bundle between the arbiter, its driver and passive observers.
interface arb_if #(
  parameter int N_REQ = arb_pkg::N_REQ_DEFAULT
) (
  input logic clk
);
  // request is level-sensitive and sampled on posedge clk; grant is a flop
  // output, one-hot or all-zero, and is held while its owner keeps requesting.
  logic             rst;
  logic [N_REQ-1:0] request;
  logic [N_REQ-1:0] grant;

  modport DUT     (input clk, rst, request, output grant);
  modport TEST    (input clk, grant, output request, rst);
  modport MONITOR (input clk, rst, request, grant);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after 'last', wrapping.
module rr_pick #(
  parameter int N_REQ = arb_pkg::N_REQ_DEFAULT,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] request,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = int'(last) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (request[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_grant2.sv
// Registered round-robin arbiter: holder keeps the grant while requesting.
module arb_grant2
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input logic clk,
  input logic rst,
  arb_if.DUT  bus
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    last_q;
  logic             found;
  logic [IW-1:0]    idx;
  logic             hold;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .request (bus.request),
    .last    (last_q),
    .found   (found),
    .idx     (idx)
  );

  // grant_q is one-hot or zero, so any overlap means the holder still requests.
  assign hold = |(grant_q & bus.request);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else if (hold) begin
      grant_q <= grant_q;
    end else if (found) begin
      grant_q      <= '0;
      grant_q[idx] <= 1'b1;
      last_q       <= idx;
    end else begin
      grant_q <= '0;
    end
  end

  assign bus.grant = grant_q;

endmodule

// File: tb/tb_arb_grant2.sv
// Randomised and directed checks of arb_grant2 against a holder/last model.
module tb_arb_grant2;

  localparam int N = 2;

  logic clk;
  int   checks;
  int   errors;

  int   m_holder;
  int   m_last;
  logic [N-1:0] exp_q[$];

  arb_if #(.N_REQ(N)) bus (.clk(clk));

  arb_grant2 #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (bus.rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_holder >= 0) g[m_holder] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
  endtask

  task automatic model_step(input logic [N-1:0] req);
    bit hit;
    int c;
    if (m_holder >= 0 && req[m_holder]) return;
    hit = 0;
    for (int i = 1; i <= N; i++) begin
      c = (m_last + i) % N;
      if (!hit && req[c]) begin
        hit      = 1;
        m_holder = c;
        m_last   = c;
      end
    end
    if (!hit) m_holder = -1;
  endtask

  // Drive at negedge, let one posedge sample it, land back on the next negedge.
  task automatic cycle(input logic [N-1:0] req);
    bus.request = req;
    @(posedge clk);
    if (!bus.rst) model_step(req);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.rst = 1'b1;
    bus.request = 2'b11;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11);
      checks++;
      if (bus.grant !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold: grant=%b expected=00", bus.grant);
      end
    end
    bus.rst = 1'b0;
    cycle(2'b11);
    checks++;
    if (bus.grant !== 2'b01 || bus.grant !== model_grant()) begin
      errors++;
      $display("FAIL reset_release: grant=%b expected=01", bus.grant);
    end
  endtask

  task automatic test_single();
    cycle(2'b00);
    cycle(2'b01);
    checks++;
    if (bus.grant !== 2'b01) begin
      errors++;
      $display("FAIL single_request: grant=%b expected=01", bus.grant);
    end
  endtask

  task automatic test_hold_handover();
    for (int i = 0; i < 5; i++) begin
      cycle(2'b11);
      checks++;
      if (bus.grant !== 2'b01) begin
        errors++;
        $display("FAIL hold cycle %0d: grant=%b expected=01", i, bus.grant);
      end
    end
    cycle(2'b10);
    checks++;
    if (bus.grant !== 2'b10) begin
      errors++;
      $display("FAIL handover: grant=%b expected=10", bus.grant);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    logic [N-1:0] req;
    want = 2'b01;
    for (int i = 0; i < 4; i++) begin
      // Current holder releases for one cycle, the other keeps requesting.
      req = ~bus.grant;
      if (bus.grant == 2'b00) req = 2'b11;
      cycle(req);
      checks++;
      if (bus.grant !== want || bus.grant !== model_grant()) begin
        errors++;
        $display("FAIL fairness step %0d: grant=%b expected=%b", i, bus.grant, want);
      end
      want = ~want;
    end
  endtask

  task automatic test_idle();
    cycle(2'b10);
    cycle(2'b00);
    checks++;
    if (bus.grant !== 2'b00) begin
      errors++;
      $display("FAIL idle: grant=%b expected=00", bus.grant);
    end
    cycle(2'b01);
    checks++;
    if (bus.grant !== 2'b01) begin
      errors++;
      $display("FAIL idle_resume: grant=%b expected=01", bus.grant);
    end
  endtask

  task automatic test_async_reset();
    cycle(2'b00);
    cycle(2'b10);
    checks++;
    if (bus.grant !== 2'b10) begin
      errors++;
      $display("FAIL async_setup: grant=%b expected=10", bus.grant);
    end
    #2;
    bus.rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.grant !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: grant=%b expected=00", bus.grant);
    end
    @(negedge clk);
    bus.rst = 1'b0;
    cycle(2'b11);
    checks++;
    if (bus.grant !== 2'b01) begin
      errors++;
      $display("FAIL async_release: grant=%b expected=01", bus.grant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    logic [N-1:0] exp;
    for (int i = 0; i < 300; i++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      cycle(req);
      exp_q.push_back(model_grant());
      exp = exp_q.pop_front();
      checks++;
      if (bus.grant !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: req=%b grant=%b expected=%b", i, req, bus.grant, exp);
      end
      checks++;
      if ($isunknown(bus.grant) || !$onehot0(bus.grant)) begin
        errors++;
        $display("FAIL onehot cycle %0d: grant=%b expected one-hot or zero", i, bus.grant);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.rst = 1'b1;
    bus.request = '0;
    model_reset();
    test_reset();
    test_single();
    test_hold_handover();
    test_fairness();
    test_idle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_grant2.md
# arb_grant2

Registered round-robin arbiter for 2 requesters (parameterizable). It grants a shared resource to exactly one requester at a time, or to none. It connects through the `arb_if` interface using its `DUT` modport, alongside a `TEST` modport (drives `request` and `rst`) and a `MONITOR` modport (all inputs). The grant is registered, and the holder keeps it while it continues to request.

## Interface
- `N_REQ`, default 2: number of requesters; must be ≥ 2.
- One clock; reset is asynchronous and active-high. The ports are named `clk` and `rst`.
- `clk` input, 1: `arb_if` clock. Passed into the interface as a port; all state updates on its rising edge.
- `rst` input, 1: asynchronous, active-high. Clears `grant` and the round-robin pointer immediately.
- `request` input, `N_REQ`: bit i high means requester i wants the resource. Level-sensitive and sampled at `posedge clk`.
- `grant` output, `N_REQ`: registered. Always one-hot or all-zero; bit i means requester i owns the resource.

## Operation
- **Reset values:** `grant` = 0 and `last` (index of the last granted requester) = `N_REQ-1`, so requester 0 has top priority after reset.
- **Decision** (each `posedge clk`, `rst` low), with `h` = current holder if `grant` ≠ 0:
  - **Hold:** if `grant[h]` is set and `request[h]` is still high, `grant` is unchanged.
  - **Pick:** otherwise, search requesters `last+1`, `last+2`, … modulo `N_REQ`. The first one with `request` high gets `grant` = one-hot of that index, and `last` becomes that index.
  - **Idle:** if no requester is high, `grant` = 0 and `last` is unchanged.
- **Release and handover:** the holder drops `request` at edge k-1, so the arbiter sees it low at edge k. At edge k the grant moves directly to the next requester in the same cycle; there is no idle gap.
- **Simultaneous requests:** round-robin order decides. After reset with `request` = 2'b11, `grant` = 01. When requester 0 releases, `grant` = 10.
- **No preemption:** a higher-priority request never takes the grant from a holder that is still requesting.
- **Invalid input:** X/Z on `request` is not resolved. `grant` must never be X after reset has been applied once.
- **Reset mid-operation:** `grant` goes to 0 asynchronously. Arbitration resumes on the first `posedge clk` with `rst` low, with requester 0 at top priority.

## Timing
- **Latency:** 1 cycle. `request` sampled at edge k gives `grant` visible after edge k.
  - A request driven nonblocking at edge t0 is sampled at t0+1 and seen as granted at t0+2.
- **Reset assertion:** asynchronous. **Reset release:** synchronous in effect, since the first update happens at the next `posedge clk`.
- **Inputs:** must be stable around `posedge clk`.
- **Output:** `grant` comes directly from a flop, with no combinational path from `request`.

## Structure
- **Package `arb_pkg`:** holds `N_REQ_DEFAULT = 2`, the typedef `req_vec_t` (`logic [N_REQ-1:0]`), and the function `onehot(idx)`.
- **Interface `arb_if`:**
  - has the clock as its port;
  - declares `request`, `grant`, `rst`;
  - modports: `DUT`, `TEST`, `MONITOR`.
- **Sub-module `rr_pick`:** combinational. Takes `request` and `last` and produces `found` and `idx`, rotating the vector by `last+1` and doing a priority-encode.
- **Top level:** `grant` and `last` flops plus the hold logic.

## Test plan
- **Reset:** hold `rst`=1 with `request`=11 → `grant`=00 throughout. Release → `grant`=01 one cycle after the first sampling edge.
- **Single request:** `request`=01 driven at the 5 ns edge (10 ns clock) → `grant`=01 when checked at 25 ns.
- **Hold and handover:** `request`=11 with 0 holding. Keep 0 high for 5 cycles → `grant` stays 01. Drop `request[0]` → `grant`=10 the next cycle.
- **Fairness:** `request`=11 with each holder releasing after 1 cycle and re-requesting → `grant` alternates 01, 10, 01, 10.
- **Idle:** `request` drops to 00 → `grant`=00 next cycle. Then `request`=01 after 1 held last → `grant`=01.
- **Async reset mid-grant:** assert `rst` between edges while `grant`=10 → `grant`=00 immediately. Release with `request`=11 → `grant`=01.
